// File: rtl/dram_bscan_chain_ctl.sv
// Boundary-scan pad chain sequencer: one capture / serial shift / update pass per accepted start.
// Every output comes from a flop that is loaded with the value the next state calls for.
module dram_bscan_chain_ctl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] chain_len,
  input  logic             extest,
  input  logic             hiz_req,
  input  logic             si_valid,
  input  logic             si_data,
  output logic             si_ready,
  output logic             so_valid,
  output logic             so_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             bsi,
  output logic             clock_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             mode_ctrl,
  output logic             hiz_n,
  input  logic             bso
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    SH_SETUP = 3'd2,
    SH_CLK   = 3'd3,
    UPDATE   = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_r, next_state_s;
  logic [LEN_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             bsi_s, so_data_s, mode_ctrl_s, hiz_n_s, err_s;
  logic             clock_dr_s, shift_dr_s, update_dr_s, si_ready_s, so_valid_s, busy_s, done_s;

  // Next-state, counter and datapath decode.
  always_comb begin
    next_state_s = state_r;
    bit_cnt_s    = bit_cnt_r;
    bsi_s        = bsi;
    so_data_s    = so_data;
    mode_ctrl_s  = mode_ctrl;
    hiz_n_s      = hiz_n;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (chain_len != {LEN_W{1'b0}}) begin
            bit_cnt_s    = chain_len;
            mode_ctrl_s  = extest;
            hiz_n_s      = ~hiz_req;
            next_state_s = CAPTURE;
          end else begin
            err_s        = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CAPTURE: next_state_s = SH_SETUP;
      SH_SETUP: begin
        // si_ready is registered high for this whole state, so valid alone completes the handshake.
        if (si_valid) begin
          bsi_s        = si_data;
          so_data_s    = bso;
          next_state_s = SH_CLK;
        end else begin
          next_state_s = SH_SETUP;
        end
      end
      SH_CLK: begin
        if (bit_cnt_r != {LEN_W{1'b0}}) begin
          bit_cnt_s = bit_cnt_r - LEN_W'(1);
        end else begin
          bit_cnt_s = {LEN_W{1'b0}};
        end
        if (bit_cnt_r > LEN_W'(1)) begin
          next_state_s = SH_SETUP;
        end else begin
          next_state_s = UPDATE;
        end
      end
      UPDATE:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Strobe values for the state being entered, so they land in flops aligned with it.
  always_comb begin
    clock_dr_s  = (next_state_s == CAPTURE) || (next_state_s == SH_CLK);
    shift_dr_s  = (next_state_s == SH_SETUP) || (next_state_s == SH_CLK);
    update_dr_s = (next_state_s == UPDATE);
    si_ready_s  = (next_state_s == SH_SETUP);
    so_valid_s  = (next_state_s == SH_CLK);
    busy_s      = (next_state_s != IDLE);
    done_s      = (next_state_s == DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= {LEN_W{1'b0}};
      bsi       <= 1'b0;
      clock_dr  <= 1'b0;
      shift_dr  <= 1'b0;
      update_dr <= 1'b0;
      mode_ctrl <= 1'b0;
      hiz_n     <= 1'b1;
      si_ready  <= 1'b0;
      so_valid  <= 1'b0;
      so_data   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      bit_cnt_r <= bit_cnt_s;
      bsi       <= bsi_s;
      clock_dr  <= clock_dr_s;
      shift_dr  <= shift_dr_s;
      update_dr <= update_dr_s;
      mode_ctrl <= mode_ctrl_s;
      hiz_n     <= hiz_n_s;
      si_ready  <= si_ready_s;
      so_valid  <= so_valid_s;
      so_data   <= so_data_s;
      busy      <= busy_s;
      done      <= done_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_dram_bscan_chain_ctl.sv
// Directed bench for dram_bscan_chain_ctl: pass timing, bit ordering, stall, error, abort and start filtering.
module tb_dram_bscan_chain_ctl;

  logic       clk = 1'b0;
  logic       reset, start, extest, hiz_req, si_valid, si_data, bso;
  logic [7:0] chain_len;
  logic       si_ready, so_valid, so_data, busy, done, err;
  logic       bsi, clock_dr, shift_dr, update_dr, mode_ctrl, hiz_n;

  int checks = 0;
  int errors = 0;

  int cdr_cnt = 0, upd_cnt = 0, done_cnt = 0, err_cnt = 0, so_cnt = 0;
  logic [63:0] sod_hist, bsi_hist;
  int so_base = 0;
  logic [7:0] si_pat, bso_pat;
  logic [31:0] pidx;

  dram_bscan_chain_ctl #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .chain_len(chain_len),
    .extest(extest), .hiz_req(hiz_req), .si_valid(si_valid), .si_data(si_data),
    .si_ready(si_ready), .so_valid(so_valid), .so_data(so_data), .busy(busy),
    .done(done), .err(err), .bsi(bsi), .clock_dr(clock_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .mode_ctrl(mode_ctrl), .hiz_n(hiz_n), .bso(bso)
  );

  always #5 clk = ~clk;

  // Per-pass bit index selects the serial input bit and the chain cell value presented on bso.
  assign pidx    = so_cnt - so_base;
  assign si_data = si_pat[pidx[2:0]];
  assign bso     = bso_pat[pidx[2:0]];

  always @(negedge clk) begin
    if (clock_dr === 1'b1) cdr_cnt++;
    if (update_dr === 1'b1) upd_cnt++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (so_valid === 1'b1) begin
      sod_hist[so_cnt[5:0]] = so_data;
      bsi_hist[so_cnt[5:0]] = bsi;
      so_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues start from IDLE and returns in the cycle done is visible; cycles counts edges from start.
  task automatic run_pass(input logic [7:0] len, input logic ext, input logic hiz,
                          input int stall_at, input int stall_len, input int restart_at,
                          output int cycles, output logic [4:0] snap);
    chain_len = len; extest = ext; hiz_req = hiz; start = 1'b1; si_valid = 1'b1;
    so_base = so_cnt;
    cycles = 0;
    snap = 5'd0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      start     = (cycles == restart_at);
      chain_len = (cycles == restart_at) ? 8'd0 : len;
      if (cycles == stall_at) si_valid = 1'b0;
      if (cycles == stall_at + stall_len) si_valid = 1'b1;
      if (cycles == stall_at + 2) snap = {bsi, clock_dr, shift_dr, si_ready, busy};
    end
  endtask

  initial begin
    int cyc, b, c0, u0, d0, e0;
    logic [4:0] snap;

    reset = 1'b1; start = 1'b0; chain_len = 8'd0; extest = 1'b0; hiz_req = 1'b0;
    si_valid = 1'b0; si_pat = 8'd0; bso_pat = 8'd0;
    step(2);
    chk("reset_vals", 32'({bsi, clock_dr, shift_dr, update_dr, mode_ctrl, hiz_n,
                           si_ready, so_valid, so_data, busy, done, err}), 32'b0000_0100_0000);
    reset = 1'b0;
    step(1);

    // Three-cell extest pass: si 1,0,1 and captured cells 0,1,1.
    si_pat = 8'b0000_0101; bso_pat = 8'b0000_0110;
    b = so_cnt; c0 = cdr_cnt; u0 = upd_cnt;
    run_pass(8'd3, 1'b1, 1'b0, -1, 0, -1, cyc, snap);
    chk("lat_len3", 32'(cyc), 32'd9);
    step(3);
    chk("clock_dr_pulses_len3", 32'(cdr_cnt - c0), 32'd4);
    chk("update_pulses_len3", 32'(upd_cnt - u0), 32'd1);
    chk("so_valid_count_len3", 32'(so_cnt - b), 32'd3);
    chk("so_data_order", 32'({sod_hist[b+2], sod_hist[b+1], sod_hist[b]}), 32'b110);
    chk("bsi_order", 32'({bsi_hist[b+2], bsi_hist[b+1], bsi_hist[b]}), 32'b101);
    chk("held_mode_hiz", 32'({mode_ctrl, hiz_n, busy}), 32'b110);

    // Four-cell pass with a five-cycle si_valid gap while bit 2 is set up.
    si_pat = 8'b0000_1101; bso_pat = 8'b0000_0000;
    c0 = cdr_cnt; u0 = upd_cnt;
    run_pass(8'd4, 1'b0, 1'b1, 4, 5, -1, cyc, snap);
    chk("lat_len4_stall5", 32'(cyc), 32'd16);
    chk("stall_hold", 32'(snap), 32'b10111);
    step(1);
    chk("clock_dr_pulses_stall", 32'(cdr_cnt - c0), 32'd5);
    chk("update_pulses_stall", 32'(upd_cnt - u0), 32'd1);
    chk("held_mode_hiz_stall", 32'({mode_ctrl, hiz_n}), 32'b00);

    // Zero-length request.
    chain_len = 8'd0; extest = 1'b1; hiz_req = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("err_pulse", 32'({err, busy}), 32'b10);
    chk("pads_unchanged", 32'({bsi, clock_dr, shift_dr, update_dr, mode_ctrl, hiz_n}), 32'b100000);
    step(1);
    chk("err_one_cycle", 32'({err, busy}), 32'b00);

    // Start during SH_SETUP is ignored; start in the DONE cycle is ignored, the next cycle accepted.
    e0 = err_cnt;
    run_pass(8'd2, 1'b1, 1'b0, -1, 0, 2, cyc, snap);
    chk("lat_restart_ignored", 32'(cyc), 32'd7);
    chain_len = 8'd1; extest = 1'b0; hiz_req = 1'b1; start = 1'b1;
    step(1);
    chk("start_at_done_ignored", 32'({busy, err, mode_ctrl}), 32'b001);
    step(1);
    start = 1'b0;
    chk("start_after_done_taken", 32'({busy, mode_ctrl, hiz_n}), 32'b100);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
    chk("lat_len1", 32'(cyc), 32'd5);
    chk("no_err_while_busy", 32'(err_cnt - e0), 32'd0);
    step(1);

    // Reset in SH_CLK of bit 2, with start raised alongside reset.
    u0 = upd_cnt; d0 = done_cnt;
    chain_len = 8'd3; extest = 1'b1; hiz_req = 1'b0; start = 1'b1; si_valid = 1'b1;
    so_base = so_cnt;
    step(1);
    start = 1'b0;
    step(4);
    chk("in_sh_clk_bit2", 32'({so_valid, clock_dr, busy}), 32'b111);
    reset = 1'b1; start = 1'b1;
    step(1);
    reset = 1'b0; start = 1'b0;
    chk("abort_reset_vals", 32'({bsi, clock_dr, shift_dr, update_dr, mode_ctrl, hiz_n,
                                 si_ready, so_valid, so_data, busy, done, err}), 32'b0000_0100_0000);
    step(4);
    chk("abort_no_update_done", 32'({upd_cnt - u0, done_cnt - d0}), 32'd0);
    u0 = upd_cnt;
    run_pass(8'd2, 1'b0, 1'b1, -1, 0, -1, cyc, snap);
    chk("lat_after_abort", 32'(cyc), 32'd7);
    step(1);
    chk("update_after_abort", 32'(upd_cnt - u0), 32'd1);
    chk("mode_hiz_after_abort", 32'({mode_ctrl, hiz_n, busy}), 32'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
